// File: rtl/card_grid_renderer.sv
// Memory-game card grid: per-card state, one shared flip animation, and a 2-stage pixel pipeline.
// Stage 1 registers rom_addr/face_idx and the draw decisions; stage 2 registers rgb/cardon.
module card_grid_renderer #(
  parameter int COLS        = 4,
  parameter int ROWS        = 4,
  parameter int CARD_W      = 100,
  parameter int CARD_H      = 100,
  parameter int ORG_X       = 121,
  parameter int ORG_Y       = 60,
  parameter int RGB_W       = 9,
  parameter int FLIP_FRAMES = 8,
  parameter int BORDER_PX   = 3,
  parameter logic [RGB_W-1:0] BACK_RGB   = 9'h1C7,
  parameter logic [RGB_W-1:0] CURSOR_RGB = 9'h1F8,
  localparam int N  = COLS * ROWS,
  localparam int IW = $clog2(N),
  localparam int AW = $clog2(CARD_W * CARD_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [9:0]       HCount,
  input  logic [9:0]       VCount,
  input  logic             frame_tick,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_idx,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic [IW-1:0]    cursor,
  output logic [AW-1:0]    rom_addr,
  output logic [IW-1:0]    face_idx,
  input  logic [RGB_W-1:0] rom_data,
  output logic             busy,
  output logic             cardon,
  output logic [RGB_W-1:0] rgb
);

  localparam int FW = (FLIP_FRAMES > 1) ? $clog2(FLIP_FRAMES) : 1;
  localparam logic [FW-1:0] LAST = FW'(FLIP_FRAMES - 1);
  localparam logic [FW-1:0] HALF = FW'(FLIP_FRAMES / 2);

  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_MATCH = 2'b11;

  typedef enum logic [1:0] {ST_DOWN, ST_UP, ST_MATCHED} card_st_t;

  card_st_t        card_st [N];
  logic            anim_act;
  logic [IW-1:0]   anim_idx;
  logic            anim_dir;   // 1 = turning face up
  logic [FW-1:0]   anim_cnt;

  assign busy      = anim_act;
  assign cmd_ready = ~anim_act;

  // Command target lookup
  logic     tgt_ok;
  card_st_t tgt_st;
  always_comb begin
    tgt_ok = (32'(cmd_idx) < N);
    tgt_st = card_st[cmd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) card_st[i] <= ST_DOWN;
      anim_act <= 1'b0;
      anim_idx <= '0;
      anim_dir <= 1'b0;
      anim_cnt <= '0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cmd_valid && !anim_act) begin
        case (cmd_op)
          OP_UP: begin
            if (tgt_ok && tgt_st == ST_DOWN) begin
              anim_act <= 1'b1;
              anim_idx <= cmd_idx;
              anim_dir <= 1'b1;
              anim_cnt <= '0;
            end else cmd_err <= 1'b1;
          end
          OP_DOWN: begin
            if (tgt_ok && tgt_st == ST_UP) begin
              anim_act <= 1'b1;
              anim_idx <= cmd_idx;
              anim_dir <= 1'b0;
              anim_cnt <= '0;
            end else cmd_err <= 1'b1;
          end
          OP_MATCH: begin
            if (tgt_ok && tgt_st == ST_UP) card_st[cmd_idx] <= ST_MATCHED;
            else cmd_err <= 1'b1;
          end
          default: ;
        endcase
      end else if (anim_act && frame_tick) begin
        // The FLIP_FRAMES-th tick lands with the counter saturated at LAST
        if (anim_cnt == LAST) begin
          anim_act          <= 1'b0;
          card_st[anim_idx] <= anim_dir ? ST_UP : ST_DOWN;
        end else begin
          anim_cnt <= anim_cnt + 1'b1;
        end
      end
    end
  end

  // Hit test against constant card edges; no division needed
  int            hp, vp, hx, vy, col, row;
  logic          col_ok, row_ok, hit;
  logic [IW-1:0] hit_idx;
  card_st_t      hit_st;
  logic          draw, border, show_face;

  always_comb begin
    hp     = 32'(HCount);
    vp     = 32'(VCount);
    col_ok = 1'b0;
    row_ok = 1'b0;
    col    = 0;
    row    = 0;
    hx     = 0;
    vy     = 0;
    for (int c = 0; c < COLS; c++) begin
      if (hp >= ORG_X + c * CARD_W && hp < ORG_X + (c + 1) * CARD_W) begin
        col_ok = 1'b1;
        col    = c;
        hx     = hp - ORG_X - c * CARD_W;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (vp >= ORG_Y + r * CARD_H && vp < ORG_Y + (r + 1) * CARD_H) begin
        row_ok = 1'b1;
        row    = r;
        vy     = vp - ORG_Y - r * CARD_H;
      end
    end
    hit     = col_ok && row_ok;
    hit_idx = IW'(row * COLS + col);
    hit_st  = card_st[hit_idx];
    draw    = enable && hit && (hit_st != ST_MATCHED);
    border  = (hit_idx == cursor) &&
              (hx < BORDER_PX || hx >= CARD_W - BORDER_PX ||
               vy < BORDER_PX || vy >= CARD_H - BORDER_PX);
    if (anim_act && anim_idx == hit_idx)
      show_face = anim_dir ? (anim_cnt >= HALF) : (anim_cnt < HALF);
    else
      show_face = (hit_st == ST_UP);
  end

  logic s1_draw, s1_border, s1_face;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      face_idx  <= '0;
      s1_draw   <= 1'b0;
      s1_border <= 1'b0;
      s1_face   <= 1'b0;
      cardon    <= 1'b0;
      rgb       <= '0;
    end else begin
      rom_addr  <= AW'(vy * CARD_W + hx);
      face_idx  <= hit_idx;
      s1_draw   <= draw;
      s1_border <= border;
      s1_face   <= show_face;
      cardon    <= s1_draw;
      if (!s1_draw)       rgb <= '0;
      else if (s1_border) rgb <= CURSOR_RGB;
      else if (s1_face)   rgb <= rom_data;
      else                rgb <= BACK_RGB;
    end
  end

endmodule

// File: tb/tb_card_grid_renderer.sv
// Directed bench for card_grid_renderer with a combinational face ROM model.
module tb_card_grid_renderer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  HCount = '0;
  logic [9:0]  VCount = '0;
  logic        frame_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_idx = '0;
  logic [3:0]  cursor = '0;
  logic        cmd_ready, cmd_err, busy, cardon;
  logic [13:0] rom_addr;
  logic [3:0]  face_idx;
  logic [8:0]  rom_data, rgb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Face ROM: pixel offset plus 32 * card index
  assign rom_data = 9'(rom_addr) + {face_idx, 5'd0};

  card_grid_renderer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .HCount(HCount), .VCount(VCount),
    .frame_tick(frame_tick), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .cursor(cursor), .rom_addr(rom_addr),
    .face_idx(face_idx), .rom_data(rom_data), .busy(busy), .cardon(cardon), .rgb(rgb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v);
    HCount = 10'(h);
    VCount = 10'(v);
    cyc(2);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] idx);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cyc(1);
    cmd_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    // Reset state, with a card pixel presented to show outputs are held
    HCount = 10'd231;
    VCount = 10'd162;
    enable = 1'b1;
    cursor = 4'd5;
    cyc(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_err", cmd_err, 0);
    check_eq("rst_cardon", cardon, 0);
    check_eq("rst_rgb", rgb, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_face_idx", face_idx, 0);
    #2 rst_n = 1'b1;
    cyc(1);

    // Top-left pixel of card 0 shows the back, 2 cycles later
    HCount = 10'd121;
    VCount = 10'd60;
    cyc(1);
    check_eq("s1_rom_addr0", rom_addr, 0);
    cyc(1);
    check_eq("origin_cardon", cardon, 1);
    check_eq("origin_rgb", rgb, 9'h1C7);

    // Stage-1 address for card 5 at offset (10,2)
    HCount = 10'd231;
    VCount = 10'd162;
    cyc(1);
    check_eq("s1_rom_addr5", rom_addr, 210);
    check_eq("s1_face_idx5", face_idx, 5);

    // Cursor border edge on card 0
    cursor = 4'd0;
    pix(123, 100);
    check_eq("border_in", rgb, 9'h1F8);
    pix(124, 100);
    check_eq("border_out", rgb, 9'h1C7);
    pix(100, 60);
    check_eq("outside_cardon", cardon, 0);
    check_eq("outside_rgb", rgb, 0);
    pix(521, 60);
    check_eq("right_edge_cardon", cardon, 0);

    // FLIP_DOWN on a DOWN card is an error with no state change
    send(2'b10, 4'd5);
    check_eq("fd_err_pulse", cmd_err, 1);
    check_eq("fd_err_busy", busy, 0);
    cyc(1);
    check_eq("fd_err_clear", cmd_err, 0);
    pix(231, 162);
    check_eq("fd_err_back", rgb, 9'h1C7);

    // FLIP_UP card 5 with a coincident frame_tick (not counted)
    frame_tick = 1'b1;
    cmd_valid  = 1'b1;
    cmd_op     = 2'b01;
    cmd_idx    = 4'd5;
    cyc(1);
    frame_tick = 1'b0;
    cmd_idx    = 4'd6;
    check_eq("fu_busy", busy, 1);
    check_eq("fu_ready", cmd_ready, 0);
    check_eq("fu_err", cmd_err, 0);
    cyc(2);
    check_eq("busy_not_accepted", cmd_err, 0);
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(2);
      check_eq($sformatf("fu_busy_t%0d", k), busy, 1);
      check_eq($sformatf("fu_rgb_t%0d", k), rgb, (k < 4) ? 9'h1C7 : 9'h172);
      tick(1);
    end
    check_eq("fu_done_busy", busy, 0);
    check_eq("fu_done_ready", cmd_ready, 1);
    cyc(2);
    check_eq("fu_up_rgb", rgb, 9'h172);
    pix(331, 162);
    check_eq("card6_still_down", rgb, 9'h1C7);

    // MATCH on UP card 5 hides it without going busy
    send(2'b11, 4'd5);
    check_eq("match_busy", busy, 0);
    check_eq("match_err", cmd_err, 0);
    pix(221, 160);
    check_eq("match_cardon", cardon, 0);
    check_eq("match_rgb", rgb, 0);
    send(2'b11, 4'd6);
    check_eq("match_down_err", cmd_err, 1);
    send(2'b01, 4'd5);
    check_eq("flip_matched_err", cmd_err, 1);
    check_eq("flip_matched_busy", busy, 0);
    send(2'b00, 4'd6);
    check_eq("nop_err", cmd_err, 0);

    // Commands still accepted with drawing disabled
    enable = 1'b0;
    send(2'b01, 4'd6);
    check_eq("en_low_busy", busy, 1);
    pix(124, 100);
    check_eq("en_low_cardon", cardon, 0);
    check_eq("en_low_rgb", rgb, 0);
    enable = 1'b1;
    tick(8);
    check_eq("c6_up_busy", busy, 0);
    pix(331, 162);
    check_eq("c6_up_rgb", rgb, 9'h192);

    // FLIP_DOWN card 6, then reset during frame 3
    send(2'b10, 4'd6);
    check_eq("c6_fd_busy", busy, 1);
    tick(3);
    cyc(2);
    check_eq("c6_fd_oldface", rgb, 9'h192);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ready", cmd_ready, 1);
    check_eq("arst_cardon", cardon, 0);
    #2 rst_n = 1'b1;
    cyc(1);
    pix(331, 162);
    check_eq("arst_c6_back", rgb, 9'h1C7);
    pix(231, 162);
    check_eq("arst_c5_back", rgb, 9'h1C7);
    check_eq("arst_c5_cardon", cardon, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
